prop_delay_meter: RTL and testbench



---
 rtl/prop_meas_pkg.sv | 14 +
 rtl/sat_counter.sv | 26 ++
 rtl/prop_delay_meter.sv | 138 +++++++++++++
 tb/tb_prop_delay_meter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/prop_meas_pkg.sv
// Shared constants and state encoding for the propagation-delay meter.
package prop_meas_pkg;

  localparam int unsigned STIM_W      = 4;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_TIMEOUT = 200;
  localparam int unsigned DEF_EVT_W   = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-edge increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prop_delay_meter.sv
// Measures cycles from a stimulus change until the AND-path output matches the golden
// response; reports per-measurement delay, timeouts, running maximum and event counts.
module prop_delay_meter
  import prop_meas_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned EVT_W   = DEF_EVT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [STIM_W-1:0] stim,
  input  logic              resp,
  input  logic              clr_stats,
  output logic              busy,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  delay,
  output logic              timeout,
  output logic [CNT_W-1:0]  max_delay,
  output logic [EVT_W-1:0]  meas_count,
  output logic [EVT_W-1:0]  restart_count
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  meas_state_e       state_q, state_d;
  logic [STIM_W-1:0] stim_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  delay_q, delay_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic              exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              tmo_q, tmo_d;
  logic              meas_inc, restart_inc;
  logic              chg;

  assign chg = (stim != stim_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stim_q  <= '1;
      cnt_q   <= '0;
      delay_q <= '0;
      max_q   <= '0;
      exp_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      max_q   <= max_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_d     = delay_q;
    max_d       = max_q;
    exp_d       = exp_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    tmo_d       = 1'b0;
    meas_inc    = 1'b0;
    restart_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (chg) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
          exp_d   = &stim;
          busy_d  = 1'b1;
        end
      end
      MEASURE: begin
        if (chg) begin
          cnt_d       = CNT_W'(1);
          exp_d       = &stim;
          restart_inc = 1'b1;
        end else if (resp == exp_q) begin
          valid_d  = 1'b1;
          delay_d  = cnt_q;
          meas_inc = 1'b1;
          if (cnt_q > max_q) max_d = cnt_q;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else if (cnt_q == TimeoutCnt) begin
          valid_d  = 1'b1;
          tmo_d    = 1'b1;
          delay_d  = TimeoutCnt;
          meas_inc = 1'b1;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    // A clear on the completion edge wins over the new maximum.
    if (clr_stats) max_d = '0;
  end

  sat_counter #(
    .W (EVT_W)
  ) u_meas_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (meas_inc),
    .clr     (clr_stats),
    .count   (meas_count)
  );

  sat_counter #(
    .W (EVT_W)
  ) u_restart_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (restart_inc),
    .clr     (clr_stats),
    .count   (restart_count)
  );

  assign busy       = busy_q;
  assign meas_valid = valid_q;
  assign delay      = delay_q;
  assign timeout    = tmo_q;
  assign max_delay  = max_q;

endmodule

// File: tb/tb_prop_delay_meter.sv
// Directed bench for prop_delay_meter with a 20-cycle timeout.
module tb_prop_delay_meter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EVT_W = 16;
  localparam int unsigned TMO   = 20;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [3:0]       stim;
  logic             resp;
  logic             clr_stats;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] delay;
  logic             timeout;
  logic [CNT_W-1:0] max_delay;
  logic [EVT_W-1:0] meas_count;
  logic [EVT_W-1:0] restart_count;

  int n_cmp = 0;
  int n_err = 0;

  prop_delay_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO),
    .EVT_W   (EVT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stim          (stim),
    .resp          (resp),
    .clr_stats     (clr_stats),
    .busy          (busy),
    .meas_valid    (meas_valid),
    .delay         (delay),
    .timeout       (timeout),
    .max_delay     (max_delay),
    .meas_count    (meas_count),
    .restart_count (restart_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Change stim so edge 0 sees it, drive resp so edge k sees the match, check the report.
  task automatic measure(input string tag, input logic [3:0] v, input logic r, input int k,
                         input int exp_max, input int exp_cnt);
    @(posedge clock); #1 stim = v;
    @(posedge clock); #1 check_eq({tag, "_busy"}, busy, 1);
    repeat (k - 1) @(posedge clock);
    #1 resp = r;
    check_eq({tag, "_early"}, meas_valid, 0);
    @(posedge clock); #1;
    check_eq({tag, "_valid"}, meas_valid, 1);
    check_eq({tag, "_delay"}, delay, k);
    check_eq({tag, "_tmo"}, timeout, 0);
    check_eq({tag, "_max"}, max_delay, exp_max);
    check_eq({tag, "_cnt"}, meas_count, exp_cnt);
    @(posedge clock); #1;
    check_eq({tag, "_pulse"}, meas_valid, 0);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    stim      = 4'b1111;
    resp      = 1'b1;
    clr_stats = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_valid", meas_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_delay", delay, 0);
    check_eq("rst_max", max_delay, 0);
    check_eq("rst_cnt", meas_count, 0);
    check_eq("rst_rcnt", restart_count, 0);

    measure("fall9", 4'b0111, 1'b0, 9, 9, 1);
    measure("rise11", 4'b1111, 1'b1, 11, 11, 2);
    measure("fall11", 4'b1101, 1'b0, 11, 11, 3);
    measure("rise2", 4'b1111, 1'b1, 2, 11, 4);

    // Restart: change at edge 0, again at edge 3, match 4 edges after that.
    @(posedge clock); #1 stim = 4'b1110;
    @(posedge clock);
    repeat (2) @(posedge clock);
    #1 stim = 4'b1100;
    @(posedge clock);
    repeat (3) @(posedge clock);
    #1 resp = 1'b0;
    check_eq("rst_mid_valid", meas_valid, 0);
    check_eq("restart_cnt", restart_count, 1);
    @(posedge clock); #1;
    check_eq("restart_valid", meas_valid, 1);
    check_eq("restart_delay", delay, 4);
    check_eq("restart_mcnt", meas_count, 5);

    // Timeout with resp stuck low against an expected 1.
    @(posedge clock); #1 stim = 4'b1111;
    @(posedge clock);
    repeat (19) @(posedge clock);
    #1;
    check_eq("tmo_early", meas_valid, 0);
    check_eq("tmo_busy", busy, 1);
    @(posedge clock); #1;
    check_eq("tmo_valid", meas_valid, 1);
    check_eq("tmo_flag", timeout, 1);
    check_eq("tmo_delay", delay, TMO);
    check_eq("tmo_max", max_delay, 11);
    check_eq("tmo_cnt", meas_count, 6);
    @(posedge clock); #1;
    check_eq("tmo_pulse", timeout, 0);

    clr_stats = 1'b1;
    @(posedge clock); #1 clr_stats = 1'b0;
    check_eq("clr_max", max_delay, 0);
    check_eq("clr_cnt", meas_count, 0);
    check_eq("clr_rcnt", restart_count, 0);

    // Asynchronous reset in the middle of a measurement.
    resp = 1'b1;
    stim = 4'b1110;
    @(posedge clock);
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_delay", delay, 0);
    check_eq("arst_valid", meas_valid, 0);
    stim = 4'b1111;
    resp = 1'b1;
    @(posedge clock); #1 reset_n = 1'b1;
    measure("post_rst", 4'b0111, 1'b0, 3, 3, 1);
    check_eq("post_rst_rcnt", restart_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
